// File: rtl/multicycle_control.sv
// multicycle_control: five-state MIPS multicycle controller for the ALU datapath.
// Define MULTICYCLE_CTRL_PERF_EN to add cycle_count/retired_count counters.
module multicycle_control #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mem_ready,
    input  logic        Zero,
    output logic        ALUScr,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [3:0]  ALUControl,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        PCWrite,
    output logic        branch_taken,
    output logic        illegal_op,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic        busy,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
`else
    output logic        busy
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic       sticky_q;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       legal;
    logic [3:0] alu_code;
    logic       alu_imm;
    logic       unused_bits;

    // Register fields are not needed by the controller
    assign unused_bits = ^instruction[25:6];

    // State register and opcode/funct latch on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid) begin
                op_q    <= instruction[31:26];
                funct_q <= instruction[5:0];
            end
        end
    end

    // Sticky illegal flag, set when an unsupported instruction is decoded
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (state == S_DECODE && !legal) begin
            sticky_q <= 1'b1;
        end
    end

    // Instruction classification and ALU operation from latched fields
    always_comb begin
        is_r     = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        legal    = 1'b0;
        alu_code = 4'b0000;
        alu_imm  = 1'b0;
        case (op_q)
            6'b000000: begin
                is_r  = 1'b1;
                legal = 1'b1;
                case (funct_q)
                    6'b100000: alu_code = 4'b0010;
                    6'b100010: alu_code = 4'b0110;
                    6'b100100: alu_code = 4'b0000;
                    6'b100101: alu_code = 4'b0001;
                    6'b101010: alu_code = 4'b0111;
                    6'b100111: alu_code = 4'b1100;
                    default:   legal    = 1'b0;
                endcase
            end
            6'b100011: begin
                is_lw    = 1'b1;
                legal    = 1'b1;
                alu_code = 4'b0010;
                alu_imm  = 1'b1;
            end
            6'b101011: begin
                is_sw    = 1'b1;
                legal    = 1'b1;
                alu_code = 4'b0010;
                alu_imm  = 1'b1;
            end
            6'b001000: begin
                legal    = 1'b1;
                alu_code = 4'b0010;
                alu_imm  = 1'b1;
            end
            6'b000100: begin
                is_beq   = 1'b1;
                legal    = 1'b1;
                alu_code = 4'b0110;
            end
            default: legal = 1'b0;
        endcase
    end

    // Next-state and output decode; reset forces every output low
    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        busy         = 1'b1;
        ALUScr       = 1'b0;
        ALUControl   = 4'b0000;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = 1'b0;
        PCWrite      = 1'b0;
        branch_taken = 1'b0;
        illegal_op   = 1'b0;
        case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (legal) begin
                    state_nxt = S_EXECUTE;
                end else begin
                    illegal_op = 1'b1;
                    PCWrite    = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ALUControl = alu_code;
                ALUScr     = alu_imm;
                if (is_beq) begin
                    PCWrite      = 1'b1;
                    branch_taken = Zero;
                    state_nxt    = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEMORY;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                ALUControl = alu_code;
                ALUScr     = alu_imm;
                MemRead    = is_lw;
                MemWrite   = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_nxt = S_WRITEBACK;
                    end else begin
                        PCWrite   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                ALUControl = alu_code;
                ALUScr     = alu_imm;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                RegDst     = is_r;
                MemtoReg   = is_lw;
                state_nxt  = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        if (ILLEGAL_TRAP != 0 && sticky_q) illegal_op = 1'b1;
        if (reset) begin
            instr_ready  = 1'b0;
            busy         = 1'b0;
            ALUScr       = 1'b0;
            ALUControl   = 4'b0000;
            RegWrite     = 1'b0;
            RegDst       = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            MemtoReg     = 1'b0;
            PCWrite      = 1'b0;
            branch_taken = 1'b0;
            illegal_op   = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Free-running cycle and retirement counters, wrapping at 32 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (PCWrite) retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule
